adc_pwr_seq: RTL
================

# adc_pwr_seq

Power-sequencing stage for the ADAS3022 evaluation board, driven by the single-bit power/clock-enable request from the Nios PIO. Converts that level request into ordered, timed enables: analog rail first, then ADC clock, then ADC-ready; power-down runs in reverse. A latched fault input forces everything off. A small Avalon-MM slave exposes status and a fault-clear register.

## Interface
- RAIL_DLY, 50000: cycles rail must be up before the clock is enabled, and cycles of rail discharge before OFF (1 ms at 50 MHz); must be ≥1.
- CLK_DLY, 5000: cycles from clock enable to ADC-ready, and cycles the clock is held off before rail removal; must be ≥1.
- CNT_W, 17: delay counter width; must hold max(RAIL_DLY, CLK_DLY)-1.

- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- en_req  in  1  power request level from the PIO, synchronous to clk.
- fault  in  1  external fault, asynchronous, active high.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, combinational, zero wait states.
- rail_en  out  1  analog rail enable, registered.
- adc_clk_en  out  1  ADC clock enable, registered.
- adc_rdy  out  1  ADC usable, registered.

## Operation
- The state register holds one of the following codes. Outputs in each state are given as rail_en/adc_clk_en/adc_rdy:
  - OFF=0: 0/0/0
  - RAIL_UP=1: 1/0/0
  - CLK_UP=2: 1/1/0
  - ON=3: 1/1/1
  - CLK_DN=4: 1/0/0
  - RAIL_DN=5: 0/0/0
  - FAULT=6: 0/0/0
- Outputs are registered, updating on the same edge the state changes, and are glitch-free.
- Delay counter: loaded with DLY-1 on entry to a timed state. The state exits on the cycle the counter is 0, so each timed state lasts exactly DLY cycles.
- Transitions, in priority order:
  - fault_sync=1 in any state → FAULT and set fault_sticky.
  - OFF: en_req=1 and fault_sticky=0 → RAIL_UP.
  - RAIL_UP: en_req=0 → RAIL_DN (load RAIL_DLY); timeout → CLK_UP.
  - CLK_UP: en_req=0 → CLK_DN; timeout → ON.
  - ON: en_req=0 → CLK_DN.
  - CLK_DN: timeout → RAIL_DN. en_req is ignored; there is no abort.
  - RAIL_DN: timeout → OFF. en_req is ignored.
  - FAULT: fault_sticky=0 and en_req=0 → OFF.
- fault passes through a 2-flop synchronizer to produce fault_sync.
- fault_sticky:
  - Set by fault_sync.
  - Cleared by a write with address=1 and writedata[0]=1.
  - If set and clear happen in the same cycle, set wins.
- Register map, read:
  - Address 0: {25'b0, state[2:0], fault_sticky, adc_rdy, adc_clk_en, rail_en} in bits 6:0.
  - Address 1: {31'b0, fault_sync}.
  - Addresses 2 and 3: 0.
- Writes to addresses 0, 2 and 3 are ignored.
- Reset: state=OFF, counter=0, fault_sticky=0, synchronizer=0. All outputs are 0 and address-0 readdata is 0.

## Timing
- en_req=1 sampled at edge N: rail_en=1 after N, adc_clk_en=1 after N+RAIL_DLY, adc_rdy=1 after N+RAIL_DLY+CLK_DLY.
- en_req=0 sampled in ON at edge M: adc_rdy and adc_clk_en go to 0 after M, rail_en goes to 0 after M+CLK_DLY, state is OFF after M+CLK_DLY+RAIL_DLY.
- fault asserted before edge F: fault_sync=1 after F+1; all outputs 0 and fault_sticky=1 after F+2. A one-cycle pulse is sufficient.
- readdata reflects register values in the same cycle as address; there is no read latency.
- reset_n low forces all outputs to 0 asynchronously, mid-sequence included. Release is synchronous to the next clk edge.

## Test plan
- Reset, then hold idle: rail_en/adc_clk_en/adc_rdy=0; address-0 read=0x00000000.
- Power-up with RAIL_DLY=4, CLK_DLY=3; en_req rises before edge 0:
  - rail_en=1 after edge 0, adc_clk_en=1 after edge 4, adc_rdy=1 after edge 7.
  - Address-0 read in ON=0x37.
- Power-down from ON, en_req falls before edge 0:
  - adc_clk_en=adc_rdy=0 after edge 0, rail_en=0 after edge 3, state=OFF (read 0x00) after edge 7.
- Abort and re-request:
  - en_req falls on the 2nd RAIL_UP cycle → RAIL_DN (read 0x50), OFF 4 cycles later.
  - en_req re-raised during RAIL_DN has no effect until OFF; the sequence then restarts.
- Fault in ON:
  - 1-cycle fault pulse: outputs 0 two edges later; read 0x68.
  - Clear write (addr 1, data 1) with en_req=1: state stays FAULT.
  - Drop en_req: OFF, read 0x00.
  - Clear written while fault is held high: fault_sticky stays 1.
- Reset mid-CLK_UP: reset_n low mid-cycle gives all outputs 0 with no clock edge; after release, state=OFF.

Source files
------------

// File: rtl/adc_pwr_seq.sv
// ADAS3022 power sequencer: orders rail -> ADC clock -> ready on request, reverses on release,
// and latches faults until cleared over a small Avalon-MM slave.
module adc_pwr_seq #(
  parameter int RAIL_DLY = 50000,
  parameter int CLK_DLY  = 5000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_req,
  input  logic        fault,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        rail_en,
  output logic        adc_clk_en,
  output logic        adc_rdy
);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    RAIL_UP = 3'd1,
    CLK_UP  = 3'd2,
    ON      = 3'd3,
    CLK_DN  = 3'd4,
    RAIL_DN = 3'd5,
    FAULT   = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] RAIL_LD = CNT_W'(RAIL_DLY - 1);
  localparam logic [CNT_W-1:0] CLK_LD  = CNT_W'(CLK_DLY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rail_q, clken_q, rdy_q;
  logic [2:0]       out_d;
  logic             sync1_q, fault_sync_q, sticky_q;
  logic             clr_wr;
  logic             tmo;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:1];
  assign tmo          = (cnt_q == '0);
  assign clr_wr       = chipselect && !write_n && (address == 2'd1) && writedata[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      fault_sync_q <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      sync1_q      <= fault;
      fault_sync_q <= sync1_q;
      // A fault seen in the same cycle as a clear keeps the flag set.
      if (fault_sync_q)  sticky_q <= 1'b1;
      else if (clr_wr)   sticky_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tmo ? '0 : cnt_q - CNT_W'(1);
    if (fault_sync_q) begin
      state_d = FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF:     if (en_req && !sticky_q) begin state_d = RAIL_UP; cnt_d = RAIL_LD; end
        RAIL_UP: if (!en_req)             begin state_d = RAIL_DN; cnt_d = RAIL_LD; end
                 else if (tmo)            begin state_d = CLK_UP;  cnt_d = CLK_LD;  end
        CLK_UP:  if (!en_req)             begin state_d = CLK_DN;  cnt_d = CLK_LD;  end
                 else if (tmo)            begin state_d = ON;      cnt_d = '0;      end
        ON:      if (!en_req)             begin state_d = CLK_DN;  cnt_d = CLK_LD;  end
        CLK_DN:  if (tmo)                 begin state_d = RAIL_DN; cnt_d = RAIL_LD; end
        RAIL_DN: if (tmo)                 begin state_d = OFF;     cnt_d = '0;      end
        FAULT:   if (!sticky_q && !en_req) begin state_d = OFF;    cnt_d = '0;      end
        default:                          begin state_d = OFF;     cnt_d = '0;      end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    out_d = 3'b000;
    case (state_d)
      RAIL_UP: out_d = 3'b100;
      CLK_UP:  out_d = 3'b110;
      ON:      out_d = 3'b111;
      CLK_DN:  out_d = 3'b100;
      default: out_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      rail_q  <= 1'b0;
      clken_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      {rail_q, clken_q, rdy_q} <= out_d;
    end
  end

  assign rail_en    = rail_q;
  assign adc_clk_en = clken_q;
  assign adc_rdy    = rdy_q;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {25'b0, state_q, sticky_q, rdy_q, clken_q, rail_q};
      2'd1:    readdata = {31'b0, fault_sync_q};
      default: readdata = '0;
    endcase
  end

endmodule
